// File: rtl/gol_display_pkg.sv
// Shared types and helpers for the Game of Life LED display path.
package gol_display_pkg;

    // Physical LED bar width on the board; one board row maps onto it.
    localparam int LED_WIDTH = 8;

    // Scanner FSM encoding.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic [1:0] REQ_CODE  = 2'd0;
    localparam logic [1:0] WAIT_CODE = 2'd1;
    localparam logic [1:0] SCAN_CODE = 2'd2;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of an index that addresses n items (at least one bit).
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gol_dwell_timer.sv
// Row dwell timer: counts enabled cycles and pulses tick on the last count.
module gol_dwell_timer
    import gol_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = cnt_width(DWELL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

    logic [CW-1:0] dwell_cnt;

    // tick marks the final cycle of a dwell period; clear has priority.
    assign tick = enable && !clear && (dwell_cnt == LAST);

    // Dwell counter: 0..DWELL_CYCLES-1, restarts on tick or clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dwell_cnt <= '0;
        end else if (clear) begin
            dwell_cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/gol_led_row_scanner.sv
// Snapshots each finished generation and scans it row by row onto the LEDs,
// then requests the next generation from the core.
//
// Step handshake: step_valid is raised by the scanner and held until the
// cycle in which step_valid && step_ready are both high; that cycle is the
// transfer, and step_valid is low on the following cycle. step_valid never
// drops without a transfer (except on reset).
module gol_led_row_scanner
    import gol_display_pkg::*;
#(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int DWELL_CYCLES  = 25_000_000,
    parameter int SCANS_PER_GEN = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ROWS*COLS-1:0]        board,
    input  logic                        board_valid,
    output logic                        step_valid,
    input  logic                        step_ready,
    output logic [COLS-1:0]             led,
    output logic [idx_width(ROWS)-1:0]  row_idx,
    output logic                        overrun,
    output state_t                      fsm_state
);

    localparam int IW = idx_width(ROWS);
    localparam int SW = cnt_width(SCANS_PER_GEN);
    localparam logic [IW-1:0] LAST_ROW  = IW'(ROWS - 1);
    localparam logic [SW-1:0] LAST_SCAN = SW'(SCANS_PER_GEN - 1);

    if (COLS != LED_WIDTH) begin : g_bad_cols
        $error("gol_led_row_scanner: COLS must equal LED_WIDTH");
    end

    state_t                 state, state_n;
    logic                   step_valid_n;
    logic [COLS-1:0]        led_n;
    logic [IW-1:0]          row_n;
    logic [IW-1:0]          row_next;
    logic                   overrun_n;
    logic [ROWS*COLS-1:0]   shadow, shadow_n;
    logic [SW-1:0]          scan_cnt, scan_n;
    logic                   handshake;
    logic                   dwell_tick;
    logic                   dwell_clear;
    logic [COLS-1:0]        shadow_rows [ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_rows
        assign shadow_rows[r] = shadow[r*COLS +: COLS];
    end

    assign handshake   = step_valid && step_ready;
    assign row_next    = (row_idx == LAST_ROW) ? '0 : row_idx + IW'(1);
    assign dwell_clear = (state != ST_SCAN);
    assign fsm_state   = state;

    gol_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .clock  (clock),
        .reset  (reset),
        .clear  (dwell_clear),
        .enable (state == ST_SCAN),
        .tick   (dwell_tick)
    );

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_REQ;
            step_valid <= 1'b0;
            led        <= '0;
            row_idx    <= '0;
            overrun    <= 1'b0;
            shadow     <= '0;
            scan_cnt   <= '0;
        end else begin
            state      <= state_n;
            step_valid <= step_valid_n;
            led        <= led_n;
            row_idx    <= row_n;
            overrun    <= overrun_n;
            shadow     <= shadow_n;
            scan_cnt   <= scan_n;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_n      = state;
        step_valid_n = step_valid;
        led_n        = led;
        row_n        = row_idx;
        overrun_n    = overrun;
        shadow_n     = shadow;
        scan_n       = scan_cnt;
        unique case (state)
            ST_REQ: begin
                if (handshake) begin
                    step_valid_n = 1'b0;
                    state_n      = ST_WAIT;
                end else begin
                    step_valid_n = 1'b1;
                end
                // A board in REQ is never the answer to our request.
                if (board_valid) begin
                    overrun_n = 1'b1;
                end
            end
            ST_WAIT: begin
                step_valid_n = 1'b0;
                if (board_valid) begin
                    shadow_n = board;
                    led_n    = board[COLS-1:0];
                    row_n    = '0;
                    scan_n   = '0;
                    state_n  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                step_valid_n = 1'b0;
                if (dwell_tick) begin
                    row_n = row_next;
                    led_n = shadow_rows[row_next];
                    if (row_idx == LAST_ROW) begin
                        if (scan_cnt == LAST_SCAN) begin
                            scan_n  = '0;
                            state_n = ST_REQ;
                        end else begin
                            scan_n = scan_cnt + SW'(1);
                        end
                    end
                end
                if (board_valid) begin
                    overrun_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_gol_led_row_scanner.sv
// Directed bench for gol_led_row_scanner (ROWS=4, COLS=8).
module tb_gol_led_row_scanner;
    import gol_display_pkg::*;

    // clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // DUT A: DWELL_CYCLES=3, SCANS_PER_GEN=2
    logic [31:0] board;
    logic        board_valid;
    logic        step_valid;
    logic        step_ready;
    logic [7:0]  led;
    logic [1:0]  row_idx;
    logic        overrun;
    state_t      fsm_state;

    // DUT B: DWELL_CYCLES=1, SCANS_PER_GEN=2
    logic [31:0] board2;
    logic        board_valid2;
    logic        step_valid2;
    logic        step_ready2;
    logic [7:0]  led2;
    logic [1:0]  row_idx2;
    logic        overrun2;
    state_t      fsm_state2;

    gol_led_row_scanner #(
        .ROWS(4), .COLS(8), .DWELL_CYCLES(3), .SCANS_PER_GEN(2)
    ) dut (
        .clock(clock), .reset(reset), .board(board), .board_valid(board_valid),
        .step_valid(step_valid), .step_ready(step_ready), .led(led),
        .row_idx(row_idx), .overrun(overrun), .fsm_state(fsm_state)
    );

    gol_led_row_scanner #(
        .ROWS(4), .COLS(8), .DWELL_CYCLES(1), .SCANS_PER_GEN(2)
    ) dut_fast (
        .clock(clock), .reset(reset), .board(board2), .board_valid(board_valid2),
        .step_valid(step_valid2), .step_ready(step_ready2), .led(led2),
        .row_idx(row_idx2), .overrun(overrun2), .fsm_state(fsm_state2)
    );

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rows_a [4];
    logic [7:0] rows_b [4];
    logic [7:0] exp_led;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cycle();
        @(negedge clock);
    endtask

    initial begin
        // board 0x44332211 rows, and board 0xF00F5AA5 rows
        rows_a[0] = 8'h11; rows_a[1] = 8'h22; rows_a[2] = 8'h33; rows_a[3] = 8'h44;
        rows_b[0] = 8'hA5; rows_b[1] = 8'h5A; rows_b[2] = 8'h0F; rows_b[3] = 8'hF0;

        reset = 1'b1;
        board = '0; board_valid = 1'b0; step_ready = 1'b1;
        board2 = '0; board_valid2 = 1'b0; step_ready2 = 1'b1;

        // reset values
        #2;
        check("rst_led", 32'(led), 32'h0);
        check("rst_row", 32'(row_idx), 32'h0);
        check("rst_sv", 32'(step_valid), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_state", 32'(fsm_state), 32'(ST_REQ));

        // 1: request after release, immediate accept
        wait_cycle();
        reset = 1'b0;
        wait_cycle();
        check("t1_sv_c1", 32'(step_valid), 32'h1);
        check("t1_led_c1", 32'(led), 32'h0);
        check("t1_row_c1", 32'(row_idx), 32'h0);
        check("t1_sv2_c1", 32'(step_valid2), 32'h1);
        wait_cycle();
        check("t1_sv_c2", 32'(step_valid), 32'h0);
        check("t1_led_c2", 32'(led), 32'h0);
        check("t1_state_c2", 32'(fsm_state), 32'(ST_WAIT));
        check("t1_sv2_c2", 32'(step_valid2), 32'h0);

        // 2 + 5: load board, two scans, fast DUT alongside
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 4; r++)
                repeat (3) exp_q.push_back(rows_a[r]);
        board = 32'h44332211; board_valid = 1'b1;
        board2 = 32'h44332211; board_valid2 = 1'b1;
        step_ready = 1'b0;
        for (int k = 0; k < 24; k++) begin
            wait_cycle();
            board_valid = 1'b0; board_valid2 = 1'b0;
            exp_led = exp_q.pop_front();
            check("t2_led", 32'(led), 32'(exp_led));
            check("t2_row", 32'(row_idx), 32'((k / 3) % 4));
            check("t2_sv", 32'(step_valid), 32'h0);
            if (k < 8) begin
                check("t5_row", 32'(row_idx2), 32'(k % 4));
                check("t5_led", 32'(led2), 32'(rows_a[k % 4]));
            end
        end

        // 3: back in REQ, request held while core is busy
        wait_cycle();
        check("t3_state", 32'(fsm_state), 32'(ST_REQ));
        check("t3_led_wrap", 32'(led), 32'h11);
        check("t3_row_wrap", 32'(row_idx), 32'h0);
        check("t3_sv_first", 32'(step_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            wait_cycle();
            check("t3_sv_hold", 32'(step_valid), 32'h1);
            check("t3_led_hold", 32'(led), 32'h11);
        end
        check("t3_ovr", 32'(overrun), 32'h0);
        step_ready = 1'b1;
        wait_cycle();
        check("t3_sv_drop", 32'(step_valid), 32'h0);
        check("t3_state_wait", 32'(fsm_state), 32'(ST_WAIT));

        // 4 + 6: second board, stray board_valid in SCAN, reset at row 2
        board = 32'hF00F5AA5; board_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_cycle();
            board_valid = 1'b0;
            check("t4_led", 32'(led), 32'(rows_b[k / 3]));
            check("t4_row", 32'(row_idx), 32'(k / 3));
            if (k == 3) check("t4_ovr_before", 32'(overrun), 32'h0);
            if (k >= 5) check("t4_ovr_sticky", 32'(overrun), 32'h1);
            if (k == 4) begin
                board = 32'hFFFFFFFF; board_valid = 1'b1;
            end
        end
        #2 reset = 1'b1;
        #1;
        check("t6_led", 32'(led), 32'h0);
        check("t6_row", 32'(row_idx), 32'h0);
        check("t6_sv", 32'(step_valid), 32'h0);
        check("t6_ovr", 32'(overrun), 32'h0);
        check("t6_state", 32'(fsm_state), 32'(ST_REQ));
        wait_cycle();
        reset = 1'b0;
        #1 check("t6_sv_rel", 32'(step_valid), 32'h0);
        wait_cycle();
        check("t6_sv_req", 32'(step_valid), 32'h1);
        check("t6_led_req", 32'(led), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
